imem_loader: RTL and testbench

- Instruction memory plus byte-serial program loader; sits directly upstream of the CPU instruction-fetch port.
- A host streams a length header and big-endian instruction words over a valid/ready byte interface. The block writes them into a 2^ADDRSIZE x WIDTH array starting at word 0.
- The CPU is held in reset throughout loading. Afterwards the block serves INS_MEM combinationally from INS_ADDR.

---
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: instruction memory with a byte-serial program loader in front of
// the CPU fetch port. Host sends a 16-bit word count, then big-endian words.
// Optional feature: define CHECKSUM_EN to require a trailing XOR checksum byte
// (covers header and data bytes) before the CPU is released.
module imem_loader #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_start,
  input  logic                ld_valid,
  input  logic [7:0]          ld_data,
  output logic                ld_ready,
  input  logic [ADDRSIZE-1:0] INS_ADDR,
  output logic [0:WIDTH-1]    INS_MEM,
  output logic                cpu_rst,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDRSIZE:0]   words_loaded
);

  localparam int unsigned DEPTH = 1 << ADDRSIZE;
  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    RUN,
`ifdef CHECKSUM_EN
    CSUM,
`endif
    ERR
  } state_t;

`ifdef CHECKSUM_EN
  localparam state_t PAY_END = CSUM;
`else
  localparam state_t PAY_END = RUN;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       header;
  logic [WIDTH-1:0]  shreg;
  logic [BW-1:0]     bcnt;
  logic [WIDTH-1:0]  mem [DEPTH];
`ifdef CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic              acc_c;
  logic              last_byte_c;
  logic              mem_we_c;
  logic              wl_hit_c;
  logic              entry_c;
  logic              ready_nxt_c;
  logic [15:0]       hdr_full_c;
  logic [WIDTH-1:0]  word_c;

  // Handshake, word assembly and end-of-payload detection
  always_comb begin
    acc_c       = ld_valid && ld_ready;
    last_byte_c = (bcnt == BW'(BYTES - 1));
    mem_we_c    = acc_c && (state == DATA) && last_byte_c;
    wl_hit_c    = ((32'(words_loaded) + 32'd1) == 32'(header));
    hdr_full_c  = {header[15:8], ld_data};
    word_c      = WIDTH'({shreg, ld_data});
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_start) state_nxt = HDR_HI;
      HDR_HI:  if (acc_c) state_nxt = HDR_LO;
      HDR_LO: begin
        if (acc_c) begin
          if (hdr_full_c == 16'd0)              state_nxt = PAY_END;
          else if (32'(hdr_full_c) > DEPTH)     state_nxt = ERR;
          else                                  state_nxt = DATA;
        end
      end
      DATA:    if (mem_we_c && wl_hit_c) state_nxt = PAY_END;
`ifdef CHECKSUM_EN
      CSUM:    if (acc_c) state_nxt = (ld_data == csum) ? RUN : ERR;
`endif
      RUN,
      ERR:     if (ld_start) state_nxt = HDR_HI;
      default: state_nxt = IDLE;
    endcase
  end

  // Fresh-load entry and ready for the upcoming state
  always_comb begin
    entry_c     = (state_nxt == HDR_HI) && (state != HDR_HI);
    ready_nxt_c = (state_nxt == HDR_HI) || (state_nxt == HDR_LO) || (state_nxt == DATA);
`ifdef CHECKSUM_EN
    ready_nxt_c = ready_nxt_c || (state_nxt == CSUM);
`endif
  end

  // State register and status outputs, registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ld_ready  <= 1'b0;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ld_ready  <= ready_nxt_c;
      cpu_rst   <= (state_nxt != RUN);
      load_done <= (state_nxt == RUN);
      load_err  <= (state_nxt == ERR);
    end
  end

  // Header capture, byte counter, partial word, word count and checksum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      header       <= '0;
      shreg        <= '0;
      bcnt         <= '0;
      words_loaded <= '0;
`ifdef CHECKSUM_EN
      csum         <= '0;
`endif
    end else if (entry_c) begin
      header       <= '0;
      shreg        <= '0;
      bcnt         <= '0;
      words_loaded <= '0;
`ifdef CHECKSUM_EN
      csum         <= '0;
`endif
    end else if (acc_c) begin
`ifdef CHECKSUM_EN
      csum <= csum ^ ld_data;
`endif
      case (state)
        HDR_HI: header[15:8] <= ld_data;
        HDR_LO: header[7:0]  <= ld_data;
        DATA: begin
          shreg <= word_c;
          if (last_byte_c) begin
            bcnt         <= '0;
            words_loaded <= words_loaded + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Instruction array write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[words_loaded[ADDRSIZE-1:0]] <= word_c;
  end

  // Zero-latency fetch while running, NOP otherwise
  assign INS_MEM = (state == RUN) ? mem[INS_ADDR] : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-level model plus directed load scenarios.
module tb_imem_loader;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned ADDRSIZE = 12;
  localparam int unsigned DEPTH    = 1 << ADDRSIZE;
  typedef logic [7:0] bq_t [$];

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                ld_start = 1'b0;
  logic                ld_valid = 1'b0;
  logic [7:0]          ld_data = 8'h00;
  logic                ld_ready;
  logic [ADDRSIZE-1:0] ins_addr = '0;
  logic [0:WIDTH-1]    ins_mem;
  logic                cpu_rst;
  logic                load_done;
  logic                load_err;
  logic [ADDRSIZE:0]   words_loaded;

  int checks = 0;
  int failures = 0;

  imem_loader #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .INS_ADDR(ins_addr),
    .INS_MEM(ins_mem), .cpu_rst(cpu_rst), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Model: the load is the list of bytes received since ld_start
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          m_csum_wait = 1'b0;
  int          m_wl = 0;
  int          m_len = 0;
  bq_t         m_q;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] e_ins;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xsum(input bq_t s);
    logic [7:0] x = 8'h00;
    foreach (s[i]) x ^= s[i];
    return x;
  endfunction

  function automatic bq_t finish_stream(input bq_t s);
    bq_t r = s;
`ifdef CHECKSUM_EN
    r.push_back(xsum(s));
`endif
    return r;
  endfunction

  task automatic payload_end();
`ifdef CHECKSUM_EN
    m_csum_wait = 1'b1;
`else
    m_active = 1'b0;
    m_done   = 1'b1;
`endif
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n;
    logic [7:0] x;
    m_q.push_back(b);
    n = m_q.size();
    if (m_csum_wait) begin
      x = 8'h00;
      for (int i = 0; i < n - 1; i++) x ^= m_q[i];
      m_active = 1'b0;
      m_csum_wait = 1'b0;
      if (x == b) m_done = 1'b1; else m_err = 1'b1;
    end else if (n == 2) begin
      m_len = int'({m_q[0], m_q[1]});
      if (m_len > int'(DEPTH)) begin
        m_active = 1'b0;
        m_err = 1'b1;
      end else if (m_len == 0) begin
        payload_end();
      end
    end else if (n > 2 && ((n - 2) % 4) == 0) begin
      m_mem[(n - 2) / 4 - 1]   = {m_q[n-4], m_q[n-3], m_q[n-2], m_q[n-1]};
      m_known[(n - 2) / 4 - 1] = 1'b1;
      m_wl = (n - 2) / 4;
      if (m_wl == m_len) payload_end();
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_csum_wait = 1'b0;
      m_wl = 0; m_q.delete();
    end else if (!m_active) begin
      if (ld_start) begin
        m_active = 1'b1; m_done = 1'b0; m_err = 1'b0; m_csum_wait = 1'b0;
        m_wl = 0; m_q.delete();
      end
    end else if (ld_valid) begin
      model_byte(ld_data);
    end
  end

  // Compare DUT against the model every cycle, mid-period
  always @(negedge clk) begin
    chk("ld_ready", 32'(ld_ready), 32'(m_active));
    chk("cpu_rst", 32'(cpu_rst), 32'(!m_done));
    chk("load_done", 32'(load_done), 32'(m_done));
    chk("load_err", 32'(load_err), 32'(m_err));
    chk("words_loaded", 32'(words_loaded), 32'(m_wl));
    e_ins = m_done ? m_mem[ins_addr] : 32'h0;
    if (!m_done || m_known[ins_addr]) chk("INS_MEM", 32'(ins_mem), e_ins);
  end

  task automatic pulse_start();
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit st);
    int n = 0;
    if (gap) begin
      ld_valid = 1'b0;
      @(posedge clk); #1;
    end
    ld_valid = 1'b1; ld_data = b; ld_start = st;
    while (!ld_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ld_ready) begin
      checks++; failures++;
      $display("FAIL handshake: ld_ready stuck low for byte %h, want 1", b);
      ld_valid = 1'b0; ld_start = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_start = 1'b0;
  endtask

  task automatic send_stream(input bq_t s, input bit gap, input int start_at);
    foreach (s[i]) send_byte(s[i], gap, (i == start_at));
  endtask

  task automatic read_at(input string name, input int a, input logic [31:0] exp);
    ins_addr = ADDRSIZE'(a);
    #1;
    chk(name, 32'(ins_mem), exp);
  endtask

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  bq_t tw, s;

  initial begin
    tw = '{8'h00, 8'h02, 8'h10, 8'h00, 8'h00, 8'h05, 8'h90, 8'h00, 8'h00, 8'h00};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_load_err", 32'(load_err), 32'h0);
    chk("rst_words", 32'(words_loaded), 32'h0);
    chk("rst_ins_mem", 32'(ins_mem), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Two-word program
`ifdef CHECKSUM_EN
    chk("csum_two_word", 32'(xsum(tw)), 32'h87);
`endif
    pulse_start();
    send_stream(finish_stream(tw), 1'b0, -1);
    chk("tw_cpu_rst", 32'(cpu_rst), 32'h0);
    chk("tw_done", 32'(load_done), 32'h1);
    chk("tw_words", 32'(words_loaded), 32'd2);
    read_at("tw_mem0", 0, 32'h10000005);
    read_at("tw_mem1", 1, 32'h90000000);

    // Same stream with idle cycles and a stray ld_start mid-data
    pulse_start();
    send_stream(finish_stream(tw), 1'b1, 4);
    chk("bp_words", 32'(words_loaded), 32'd2);
    read_at("bp_mem0", 0, 32'h10000005);
    read_at("bp_mem1", 1, 32'h90000000);

    // Empty program
    s = '{8'h00, 8'h00};
    pulse_start();
    send_stream(finish_stream(s), 1'b0, -1);
    chk("empty_done", 32'(load_done), 32'h1);
    chk("empty_words", 32'(words_loaded), 32'd0);
    read_at("empty_mem1", 1, 32'h90000000);

    // Oversize header 4097
    s = '{8'h10, 8'h01};
    pulse_start();
    send_stream(s, 1'b0, -1);
    chk("ovr_err", 32'(load_err), 32'h1);
    chk("ovr_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("ovr_ready", 32'(ld_ready), 32'h0);
    chk("ovr_ins_mem", 32'(ins_mem), 32'h0);
    pulse_start();
    chk("ovr_restart_ready", 32'(ld_ready), 32'h1);
    chk("ovr_restart_err", 32'(load_err), 32'h0);

    // Reset after six data bytes
    s = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_stream(s, 1'b0, -1);
    rst = 1'b0;
    #1;
    chk("mid_rst_words", 32'(words_loaded), 32'h0);
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("mid_rst_ready", 32'(ld_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    s = '{8'h00, 8'h00};
    pulse_start();
    send_stream(finish_stream(s), 1'b0, -1);
    read_at("mid_rst_mem0", 0, 32'hAABBCCDD);
    read_at("mid_rst_mem1", 1, 32'h90000000);
    s = '{8'h00, 8'h01, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    pulse_start();
    send_stream(finish_stream(s), 1'b0, -1);
    chk("reload_words", 32'(words_loaded), 32'd1);
    read_at("reload_mem0", 0, 32'h5A5A5A5A);

`ifdef CHECKSUM_EN
    // Bad checksum after a valid two-word payload
    s = tw;
    s.push_back(8'h00);
    pulse_start();
    send_stream(s, 1'b0, -1);
    chk("csum_bad_err", 32'(load_err), 32'h1);
    chk("csum_bad_done", 32'(load_done), 32'h0);
    chk("csum_bad_words", 32'(words_loaded), 32'd2);
    s = '{8'h00, 8'h00};
    pulse_start();
    send_stream(finish_stream(s), 1'b0, -1);
    read_at("csum_bad_mem0", 0, 32'h10000005);
    read_at("csum_bad_mem1", 1, 32'h90000000);
`endif

    // Full array: header 0x1000, word i = 0x1234_0000 | i
    s = '{8'h10, 8'h00};
    for (int i = 0; i < int'(DEPTH); i++) begin
      s.push_back(8'h12);
      s.push_back(8'h34);
      s.push_back(8'(i >> 8));
      s.push_back(8'(i));
    end
    pulse_start();
    send_stream(finish_stream(s), 1'b0, -1);
    chk("full_words", 32'(words_loaded), 32'd4096);
    chk("full_done", 32'(load_done), 32'h1);
    read_at("full_last", 4095, 32'h12340FFF);
    read_at("full_first", 0, 32'h12340000);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
